// File: rtl/ir_decoder.sv
// Instruction-register field decoder: selects ra/rb/rc under control strobes, produces
// register number and one-hot enables, opcode, sign-extended constant and a sticky conflict flag.
module ir_decoder (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] ir_val,
   input  logic        Gra,
   input  logic        Grb,
   input  logic        Grc,
   input  logic        Rin,
   input  logic        Rout,
   input  logic        BAout,
   output logic [3:0]  rnum,
   output logic [15:0] reg_in,
   output logic [15:0] reg_out,
   output logic        r0_zero,
   output logic [4:0]  opcode,
   output logic [31:0] c_sext,
   output logic        sel_err
);

   logic sel_valid;
   logic conflict;
   logic [15:0] onehot;

   // Fixed priority Gra > Grb > Grc; a conflict never changes which field wins.
   always_comb begin
      rnum = 4'd0;
      if (Gra)
         rnum = ir_val[26:23];
      else if (Grb)
         rnum = ir_val[22:19];
      else if (Grc)
         rnum = ir_val[18:15];
   end

   assign sel_valid = Gra | Grb | Grc;
   assign conflict  = (Gra & Grb) | (Gra & Grc) | (Grb & Grc);
   assign onehot    = 16'd1 << rnum;

   // Base-address drive of R0 means "constant zero on the bus", so R0 itself stays off.
   always_comb begin
      r0_zero = BAout & (rnum == 4'd0);
      reg_in  = (sel_valid & Rin) ? onehot : 16'd0;
      reg_out = 16'd0;
      if (sel_valid & (Rout | BAout) & ~r0_zero)
         reg_out = onehot;
   end

   assign opcode = ir_val[31:27];
   assign c_sext = {{13{ir_val[18]}}, ir_val[18:0]};

   always_ff @(posedge clk) begin
      if (rst)
         sel_err <= 1'b0;
      else if (conflict)
         sel_err <= 1'b1;
   end

endmodule

// File: tb/tb_ir_decoder.sv
// Self-checking bench for ir_decoder: directed cases then randomized stimulus
// against an arithmetic reference model.
module tb_ir_decoder;

   logic        clk;
   logic        rst;
   logic [31:0] ir_val;
   logic        Gra, Grb, Grc, Rin, Rout, BAout;
   logic [3:0]  rnum;
   logic [15:0] reg_in, reg_out;
   logic        r0_zero;
   logic [4:0]  opcode;
   logic [31:0] c_sext;
   logic        sel_err;

   int assertCount = 0;
   int failCount   = 0;
   bit modelErr    = 0;

   ir_decoder dut (
      .clk(clk), .rst(rst), .ir_val(ir_val),
      .Gra(Gra), .Grb(Grb), .Grc(Grc),
      .Rin(Rin), .Rout(Rout), .BAout(BAout),
      .rnum(rnum), .reg_in(reg_in), .reg_out(reg_out), .r0_zero(r0_zero),
      .opcode(opcode), .c_sext(c_sext), .sel_err(sel_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      assertCount++;
      if (observed !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic [31:0] ir, input bit a, input bit b, input bit c,
                                input bit rin, input bit rout, input bit ba);
      ir_val = ir; Gra = a; Grb = b; Grc = c; Rin = rin; Rout = rout; BAout = ba;
      #1;
   endtask

   // Advance one rising edge, updating the reference flag from the inputs seen at that edge.
   task automatic tickClock();
      int strobes;
      @(posedge clk);
      strobes = int'(Gra) + int'(Grb) + int'(Grc);
      if (rst) modelErr = 0;
      else if (strobes >= 2) modelErr = 1;
      #1;
   endtask

   task automatic checkModel(input string tag);
      int unsigned fieldA, fieldB, fieldC, expRnum, expIn, expOut, expOp, expC;
      bit valid, expR0;
      fieldA = (ir_val / (2**23)) % 16;
      fieldB = (ir_val / (2**19)) % 16;
      fieldC = (ir_val / (2**15)) % 16;
      expRnum = Gra ? fieldA : (Grb ? fieldB : (Grc ? fieldC : 0));
      valid = Gra || Grb || Grc;
      expIn = (valid && Rin) ? (32'd1 << expRnum) : 0;
      expR0 = BAout && (expRnum == 0);
      expOut = (valid && (Rout || BAout) && !expR0) ? (32'd1 << expRnum) : 0;
      expOp = ir_val / (2**27);
      expC = ir_val % (2**19);
      if (expC >= 2**18) expC = expC - 2**19;
      checkOutput({tag, ".rnum"},    32'(rnum),    expRnum);
      checkOutput({tag, ".reg_in"},  32'(reg_in),  expIn);
      checkOutput({tag, ".reg_out"}, 32'(reg_out), expOut);
      checkOutput({tag, ".r0_zero"}, 32'(r0_zero), 32'(expR0));
      checkOutput({tag, ".opcode"},  32'(opcode),  expOp);
      checkOutput({tag, ".c_sext"},  c_sext,       expC);
      checkOutput({tag, ".sel_err"}, 32'(sel_err), 32'(modelErr));
   endtask

   initial begin
      logic [31:0] irF;
      logic [31:0] irR;
      rst = 1'b1;
      applyStimulus(32'd0, 0, 0, 0, 0, 0, 0);
      tickClock();
      checkOutput("reset_sel_err", 32'(sel_err), 32'd0);
      rst = 1'b0;
      #1;

      irF = (32'd5 << 23) | (32'd6 << 19) | (32'd7 << 15);
      applyStimulus(irF, 1, 0, 0, 0, 0, 0);
      checkOutput("sel_ra", 32'(rnum), 32'd5);
      applyStimulus(irF, 0, 1, 0, 0, 0, 0);
      checkOutput("sel_rb", 32'(rnum), 32'd6);
      applyStimulus(irF, 0, 0, 1, 0, 0, 0);
      checkOutput("sel_rc", 32'(rnum), 32'd7);
      applyStimulus(irF, 0, 0, 0, 0, 0, 0);
      checkOutput("sel_none", 32'(rnum), 32'd0);

      applyStimulus(irF, 0, 1, 0, 1, 0, 0);
      checkOutput("rin_reg_in", 32'(reg_in), 32'h0040);
      checkOutput("rin_reg_out", 32'(reg_out), 32'h0000);
      applyStimulus(irF, 0, 1, 0, 0, 1, 0);
      checkOutput("rout_reg_out", 32'(reg_out), 32'h0040);
      checkOutput("rout_reg_in", 32'(reg_in), 32'h0000);

      applyStimulus(32'd0, 1, 0, 0, 0, 0, 1);
      checkOutput("ba_r0_reg_out", 32'(reg_out), 32'h0000);
      checkOutput("ba_r0_zero", 32'(r0_zero), 32'd1);
      applyStimulus(32'd3 << 23, 1, 0, 0, 0, 0, 1);
      checkOutput("ba_r3_reg_out", 32'(reg_out), 32'h0008);
      checkOutput("ba_r3_zero", 32'(r0_zero), 32'd0);

      applyStimulus(32'hF804_0001, 0, 0, 0, 0, 0, 0);
      checkOutput("opcode_1f", 32'(opcode), 32'h1F);
      checkOutput("c_sext_neg", c_sext, 32'hFFFC_0001);
      applyStimulus(32'h0003_FFFF, 0, 0, 0, 0, 0, 0);
      checkOutput("c_sext_pos", c_sext, 32'h0003_FFFF);

      // A conflict pulse that ends before the edge must not set the flag.
      applyStimulus(irF, 1, 1, 0, 0, 0, 0);
      applyStimulus(irF, 0, 0, 0, 0, 0, 0);
      tickClock();
      checkOutput("pulse_no_err", 32'(sel_err), 32'd0);

      applyStimulus(irF, 1, 0, 1, 0, 0, 0);
      checkOutput("prio_rnum", 32'(rnum), 32'd5);
      checkOutput("prio_err_before_edge", 32'(sel_err), 32'd0);
      tickClock();
      checkOutput("conflict_err", 32'(sel_err), 32'd1);
      applyStimulus(irF, 0, 0, 0, 0, 0, 0);
      tickClock();
      checkOutput("err_sticky", 32'(sel_err), 32'd1);

      applyStimulus(irF, 1, 0, 1, 0, 0, 0);
      rst = 1'b1;
      tickClock();
      checkOutput("reset_beats_conflict", 32'(sel_err), 32'd0);
      rst = 1'b0;
      tickClock();
      checkOutput("err_after_reset", 32'(sel_err), 32'd1);

      rst = 1'b1;
      applyStimulus(irF, 0, 0, 0, 0, 0, 0);
      tickClock();
      rst = 1'b0;
      modelErr = 0;
      checkOutput("reset_again", 32'(sel_err), 32'd0);

      for (int i = 0; i < 300; i++) begin
         bit a, b, c, ba;
         int pick;
         irR = $urandom;
         pick = $urandom_range(0, 9);
         a = 0; b = 0; c = 0;
         if (pick < 2) begin
            a = 1'($urandom); b = 1'($urandom); c = 1'($urandom);
         end else if (pick < 4) a = 1;
         else if (pick < 6) b = 1;
         else if (pick < 8) c = 1;
         if ($urandom_range(0, 3) == 0) irR[26:23] = 4'd0;
         ba = 1'($urandom);
         if (!(a || b || c)) ba = 0;
         applyStimulus(irR, a, b, c, 1'($urandom), 1'($urandom), ba);
         rst = ($urandom_range(0, 11) == 0);
         checkModel("rand");
         tickClock();
         checkOutput("rand_sel_err", 32'(sel_err), 32'(modelErr));
      end
      rst = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
